// File: rtl/apb4_master_queued.sv
// rtl/apb4_master_queued.sv - Queued APB4 requester with command FIFO, wait-state timeout and in-order responses
module apb4_master_queued #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_cmd_valid,
    output logic                          o_cmd_ready,
    input  logic [ADDR_WIDTH-1:0]         i_cmd_addr,
    input  logic                          i_cmd_write,
    input  logic [DATA_WIDTH-1:0]         i_cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]       i_cmd_strb,
    input  logic [2:0]                    i_cmd_prot,
    output logic                          o_rsp_valid,
    output logic [DATA_WIDTH-1:0]         o_rsp_rdata,
    output logic                          o_rsp_slverr,
    output logic                          o_rsp_timeout,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic [ADDR_WIDTH-1:0]         PADDR,
    output logic                          PWRITE,
    output logic [DATA_WIDTH-1:0]         PWDATA,
    output logic [DATA_WIDTH/8-1:0]       PSTRB,
    output logic [2:0]                    PPROT,
    output logic                          PSELx,
    output logic                          PENABLE,
    input  logic [DATA_WIDTH-1:0]         PRDATA,
    input  logic                          PREADY,
    input  logic                          PSLVERR
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TO_EN  = (TIMEOUT_CYCLES != 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_mem  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] wdata_mem [FIFO_DEPTH];
    logic [STRB_W-1:0]     strb_mem  [FIFO_DEPTH];
    logic [2:0]            prot_mem  [FIFO_DEPTH];
    logic                  write_mem [FIFO_DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]      level_q, level_d;
    logic [WAIT_W-1:0]     wait_q;

    logic [ADDR_WIDTH-1:0] paddr_q;
    logic                  pwrite_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic [STRB_W-1:0]     pstrb_q;
    logic [2:0]            pprot_q;

    logic                  rsp_valid_q, rsp_slverr_q, rsp_timeout_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;

    logic fifo_empty, fifo_full, push, pop;
    logic xfer_done, timed_out, finish;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LVL_FULL);
    assign push       = i_cmd_valid && !fifo_full;
    assign xfer_done  = (state_q == S_ACCESS) && PREADY;
    assign timed_out  = TO_EN && (state_q == S_ACCESS) && !PREADY && (wait_q == WAIT_LAST);
    assign finish     = xfer_done || timed_out;
    // A completing transfer pops the next command in the same cycle, so there is no IDLE gap.
    assign pop        = !fifo_empty && ((state_q == S_IDLE) || finish);
    assign level_d    = level_q + LVL_W'(push) - LVL_W'(pop);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (pop) state_d = S_SETUP;
            S_SETUP:  state_d = S_ACCESS;
            S_ACCESS: if (finish) state_d = pop ? S_SETUP : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        PSELx   = (state_q != S_IDLE);
        PENABLE = (state_q == S_ACCESS);
    end

    // Storage has no reset; the pointers and level alone define its contents.
    always_ff @(posedge i_clk) begin
        if (push) begin
            addr_mem[wr_ptr_q]  <= i_cmd_addr;
            write_mem[wr_ptr_q] <= i_cmd_write;
            wdata_mem[wr_ptr_q] <= i_cmd_write ? i_cmd_wdata : '0;
            strb_mem[wr_ptr_q]  <= i_cmd_write ? i_cmd_strb : '0;
            prot_mem[wr_ptr_q]  <= i_cmd_prot;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            level_q <= level_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            pprot_q  <= '0;
        end else if (pop) begin
            paddr_q  <= addr_mem[rd_ptr_q];
            pwrite_q <= write_mem[rd_ptr_q];
            pwdata_q <= wdata_mem[rd_ptr_q];
            pstrb_q  <= strb_mem[rd_ptr_q];
            pprot_q  <= prot_mem[rd_ptr_q];
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wait_q <= '0;
        end else if (state_q == S_SETUP) begin
            wait_q <= '0;
        end else if (TO_EN && (state_q == S_ACCESS) && !PREADY && !timed_out) begin
            wait_q <= wait_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            rsp_valid_q   <= finish;
            rsp_rdata_q   <= (xfer_done && !pwrite_q) ? PRDATA : '0;
            rsp_slverr_q  <= xfer_done ? PSLVERR : timed_out;
            rsp_timeout_q <= timed_out;
        end
    end

    assign o_cmd_ready   = !fifo_full;
    assign o_fifo_level  = level_q;
    assign o_busy        = (state_q != S_IDLE) || !fifo_empty;
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_rdata   = rsp_rdata_q;
    assign o_rsp_slverr  = rsp_slverr_q;
    assign o_rsp_timeout = rsp_timeout_q;
    assign PADDR         = paddr_q;
    assign PWRITE        = pwrite_q;
    assign PWDATA        = pwdata_q;
    assign PSTRB         = pstrb_q;
    assign PPROT         = pprot_q;

endmodule

// File: tb/tb_apb4_master_queued.sv
// tb/tb_apb4_master_queued.sv - Directed self-checking bench for apb4_master_queued
module tb_apb4_master_queued;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_strb = '0;
    logic [2:0]  cmd_prot = '0;
    logic        rsp_valid, rsp_slverr, rsp_timeout, busy;
    logic [31:0] rsp_rdata;
    logic [2:0]  fifo_level;
    logic [31:0] paddr, pwdata, prdata;
    logic        pwrite, psel, penable;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int acc_n = 0;
    int ws = 0;
    int pen_cnt = 0;
    bit hold = 1'b0;
    logic [31:0] rd_key = 32'h5A5A_0000;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_strb;

    logic [31:0] rq_rdata[$];
    logic        rq_slverr[$];
    logic        rq_to[$];
    int          rq_cyc[$];

    apb4_master_queued #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_addr(cmd_addr), .i_cmd_write(cmd_write), .i_cmd_wdata(cmd_wdata),
        .i_cmd_strb(cmd_strb), .i_cmd_prot(cmd_prot),
        .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_slverr(rsp_slverr),
        .o_rsp_timeout(rsp_timeout), .o_busy(busy), .o_fifo_level(fifo_level),
        .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PSELx(psel), .PENABLE(penable), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: sample 1ns after the edge, then act as the completer for the coming edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (rsp_valid) begin
            rq_rdata.push_back(rsp_rdata);
            rq_slverr.push_back(rsp_slverr);
            rq_to.push_back(rsp_timeout);
            rq_cyc.push_back(cyc);
        end
        if (penable) pen_cnt++;
        if (psel) begin
            bus_addr  = paddr;
            bus_wdata = pwdata;
            bus_strb  = pstrb;
        end
        prdata = paddr ^ rd_key;
        if (psel && penable && !hold) begin
            pready = (acc_n >= ws);
            acc_n++;
        end else begin
            pready = 1'b0;
            if (!penable) acc_n = 0;
        end
    endtask

    task automatic push(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] s, input logic [2:0] p);
        int n;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_write = w;
        cmd_wdata = d;
        cmd_strb  = s;
        cmd_prot  = p;
        n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        if (!cmd_ready) check("push_wait", 64'd0, 64'd1);
        else begin
            tick();
            acc_cyc = cyc;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n);
        int k;
        k = 0;
        while (rq_rdata.size() < n && k < 200) begin
            tick();
            k++;
        end
        check("rsp_count", rq_rdata.size(), n);
    endtask

    task automatic clear_q();
        rq_rdata.delete();
        rq_slverr.delete();
        rq_to.delete();
        rq_cyc.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_paddr", paddr, 0);
        check("rst_level", fifo_level, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        rst_n = 1'b1;
        tick();

        // 1: write with two wait states
        clear_q(); ws = 2; pen_cnt = 0;
        push(32'h1000, 1'b1, 32'hDEADBEEF, 4'hF, 3'd0);
        wait_rsp(1);
        repeat (3) tick();
        check("t1_pulses", rq_rdata.size(), 1);
        check("t1_penable_cycles", pen_cnt, 3);
        check("t1_paddr", bus_addr, 32'h1000);
        check("t1_pstrb", bus_strb, 4'hF);
        check("t1_pwdata", bus_wdata, 32'hDEADBEEF);
        check("t1_slverr", rq_slverr[0], 0);
        check("t1_rdata", rq_rdata[0], 0);

        // 2: zero-wait read, latency accept edge -> response
        clear_q(); ws = 0; rd_key = 32'hCAFEAABE;
        push(32'h1000, 1'b0, 32'h12345678, 4'hF, 3'd2);
        wait_rsp(1);
        check("t2_rdata", rq_rdata[0], 32'hCAFEBABE);
        check("t2_latency", rq_cyc[0] - acc_cyc, 3);
        check("t2_pstrb", bus_strb, 4'h0);
        check("t2_pwdata", bus_wdata, 32'h0);
        check("t2_slverr", rq_slverr[0], 0);
        rd_key = 32'h5A5A_0000;

        // 3: fill the FIFO behind a held transfer, then drain back-to-back
        clear_q(); hold = 1'b1;
        for (int i = 0; i < 5; i++) push(32'h2000 + 32'(4 * i), 1'b0, 32'h0, 4'h0, 3'd0);
        check("t3_full_ready", cmd_ready, 0);
        check("t3_full_level", fifo_level, 4);
        hold = 1'b0;
        push(32'h2014, 1'b0, 32'h0, 4'h0, 3'd0);
        wait_rsp(6);
        for (int i = 0; i < 6; i++) begin
            check("t3_rdata", rq_rdata[i], (32'h2000 + 32'(4 * i)) ^ 32'h5A5A_0000);
            check("t3_timeout", rq_to[i], 0);
        end
        for (int i = 1; i < 6; i++) check("t3_spacing", rq_cyc[i] - rq_cyc[i-1], 2);

        // 4: slave error
        clear_q(); pslverr = 1'b1;
        push(32'h3000, 1'b1, 32'h0BADF00D, 4'hF, 3'd0);
        wait_rsp(1);
        pslverr = 1'b0;
        check("t4_slverr", rq_slverr[0], 1);
        check("t4_timeout", rq_to[0], 0);
        check("t4_rdata", rq_rdata[0], 0);

        // 5: timeout after 8 ACCESS cycles, next command still completes
        clear_q(); ws = 99; pen_cnt = 0;
        push(32'h4000, 1'b0, 32'h0, 4'h0, 3'd0);
        push(32'h4004, 1'b1, 32'h11112222, 4'h3, 3'd1);
        wait_rsp(1);
        ws = 0;
        check("t5_penable_cycles", pen_cnt, 8);
        check("t5_timeout", rq_to[0], 1);
        check("t5_slverr", rq_slverr[0], 1);
        check("t5_rdata", rq_rdata[0], 0);
        wait_rsp(2);
        check("t5_next_timeout", rq_to[1], 0);
        check("t5_next_slverr", rq_slverr[1], 0);
        check("t5_next_paddr", bus_addr, 32'h4004);
        check("t5_next_pstrb", bus_strb, 4'h3);

        // 6: reset mid-ACCESS with two commands queued
        clear_q(); hold = 1'b1;
        for (int i = 0; i < 3; i++) push(32'h5000 + 32'(4 * i), 1'b0, 32'h0, 4'h0, 3'd0);
        check("t6_in_access", penable, 1);
        check("t6_level", fifo_level, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_psel", psel, 0);
        check("t6_rst_penable", penable, 0);
        check("t6_rst_level", fifo_level, 0);
        check("t6_rst_busy", busy, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        hold = 1'b0;
        repeat (4) tick();
        check("t6_no_rsp", rq_rdata.size(), 0);
        push(32'h6000, 1'b0, 32'h0, 4'h0, 3'd0);
        wait_rsp(1);
        check("t6_after_rdata", rq_rdata[0], 32'h5A5A_6000);
        check("t6_after_timeout", rq_to[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
